fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  the reset: asynchronous, active-low.
REQ-004 SHALL have port En  in  1  decode-register enable; 1 = downstream takes the current InstrF/PCPlus4F this cycle.
REQ-005 SHALL have port Redirect  in  1  branch/jump taken; restart fetch at RedirectPC.
REQ-006 SHALL have port RedirectPC  in  32  new fetch address; word-aligned.
REQ-007 SHALL have port IReq  out  1  instruction-memory request valid.
REQ-008 SHALL have port IAddr  out  32  request address (current PC).
REQ-009 SHALL have port IGnt  in  1  memory accepts the request this cycle.
REQ-010 SHALL have port IRValid  in  1  read data valid; responses return in order, at least 1 cycle after grant.
REQ-011 SHALL have port IRData  in  32  instruction word.
REQ-012 SHALL have port InstrF  out  32  instruction to the decode register; 0 (NOP) when ValidF=0.
REQ-013 SHALL have port PCPlus4F  out  32  address of InstrF plus 4; 0 when ValidF=0.
REQ-014 SHALL have port ValidF  out  1  InstrF/PCPlus4F hold a real fetched instruction.

Function
REQ-015 SHALL hold a 32-bit PC; IAddr = PC; PC advances by 4 only on IReq&IGnt, modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-016 SHALL hold a 2-entry in-order buffer of {instr, pc+4}; InstrF/PCPlus4F/ValidF come from its head combinationally.
REQ-017 SHALL count outstanding requests (0..2) and buffered entries; IReq = 1 only when outstanding + buffered < 2 and Redirect = 0.
REQ-018 SHALL push IRData with the PC+4 of its request into the buffer on IRValid when the drop count is 0; pop the head when En&ValidF.
REQ-019 SHALL allow push and pop in the same cycle; the credit rule of REQ-017 guarantees no overflow.
REQ-020 SHALL, on Redirect, load PC with RedirectPC, empty the buffer, discard any IRValid in that cycle, and set the drop count to the outstanding requests remaining after that cycle.
REQ-021 SHALL, while the drop count > 0, discard each IRValid and decrement the drop count; discarded responses free their credit.
REQ-022 SHALL ignore En while ValidF = 0; a stall (En = 0) with a full buffer holds all outputs and blocks requests.
REQ-023 SHALL ignore IRValid when no request is outstanding.
REQ-024 SHALL keep the fetch-to-ValidF latency at 1 cycle after IRValid for an empty buffer; back-to-back zero-wait memory yields one instruction per cycle.

Reset
REQ-025 SHALL, while rst = 0, force PC = RESET_PC, buffer empty, outstanding = 0, drop = 0, IReq = 0, ValidF = 0, InstrF = 0, PCPlus4F = 0.
REQ-026 SHALL, on reset assertion mid-transfer, lose all in-flight responses; the memory is reset by the same rst.
REQ-027 SHALL issue the first request in the first cycle after rst deasserts.

Structure
REQ-028 SHALL take RESET_PC default, NOP encoding (32'h0) and buffer depth (2) from the shared CPU package.
REQ-029 SHALL implement the 2-entry buffer as one sub-module, fetch_buf (push, pop, flush, count, head data).

Verification
REQ-030 Reset, zero-wait memory (IGnt = 1, IRValid 1 cycle later), En = 1 -> ValidF from cycle 2; PCPlus4F = 4, 8, 12, ...; one instruction per cycle.
REQ-031 En = 0 for 5 cycles after the first instruction -> buffer fills to 2; IReq = 0; InstrF held at the PC = 0 word; resumes in order at PCPlus4F = 4 then 8.
REQ-032 Redirect to 32'h0000_0100 with 2 requests outstanding -> the next 2 IRValid are discarded; next ValidF shows PCPlus4F = 32'h104.
REQ-033 Redirect with simultaneous IRValid and En -> the response is dropped, the buffer is empty next cycle, and IAddr = RedirectPC.
REQ-034 RESET_PC = 32'hFFFF_FFF8 -> IAddr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; PCPlus4F wraps to 0.
REQ-035 rst asserted with 1 request outstanding and buffer full -> all outputs 0 immediately; after release IAddr = RESET_PC, and no stale data appears.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions used by the instruction fetch unit.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   NOP_INSTR        : instruction word presented when nothing valid is held
//   BUF_DEPTH        : fetch buffer depth, which is also the request credit limit
//   fetch_entry_t    : one buffered instruction with the address after it
//   resp_pc_plus4()  : recovers the PC+4 of the oldest live request
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int          BUF_DEPTH        = 2;
    localparam int          CNT_W            = $clog2(BUF_DEPTH + 1);
    localparam int          IDX_W            = $clog2(BUF_DEPTH);

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } fetch_entry_t;

    // Requests issued since the last redirect have consecutive addresses and
    // the PC already points past the youngest one. With 'live' such requests
    // in flight, the oldest one's PC+4 is PC - 4*(live-1).
    function automatic logic [31:0] resp_pc_plus4(input logic [31:0] pc,
                                                  input cnt_t        live);
        cnt_t back;
        back = live - cnt_t'(1);
        return pc - {{(30-CNT_W){1'b0}}, back, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// In-order fetch buffer (shift-register FIFO, BUF_DEPTH entries).
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   push, push_data   : write an entry at the tail
//   pop               : drop the head (ignored when empty)
//   flush             : empty the buffer; dominates push/pop
//   count             : number of valid entries
//   head              : oldest entry (meaningful only when count != 0)
module fetch_buf
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output cnt_t         count,
    output fetch_entry_t head
);

    fetch_entry_t entry_reg  [BUF_DEPTH];
    fetch_entry_t entry_next [BUF_DEPTH];
    cnt_t         count_reg;
    cnt_t         count_next;
    logic         pop_ok;
    cnt_t         wr_idx;
    logic [IDX_W-1:0] wr_slot;

    assign pop_ok  = pop && (count_reg != '0);
    // A same-cycle pop shifts everything down first, so the tail moves too.
    assign wr_idx  = count_reg - cnt_t'(pop_ok);
    assign wr_slot = wr_idx[IDX_W-1:0];

    always_comb begin
        entry_next = entry_reg;
        if (pop_ok) begin
            for (int i = 0; i < BUF_DEPTH - 1; i++) begin
                entry_next[i] = entry_reg[i+1];
            end
        end
        if (push) begin
            entry_next[wr_slot] = push_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count_reg + cnt_t'(push) - cnt_t'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            count_reg <= count_next;
            // Entries are only meaningful below count, so flush leaves data as is.
            if (!flush) begin
                for (int i = 0; i < BUF_DEPTH; i++) begin
                    entry_reg[i] <= entry_next[i];
                end
            end
        end
    end

    assign count = count_reg;
    assign head  = entry_reg[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order requests to instruction memory,
// buffers returned words with their PC+4 and presents them to decode.
// Ports:
//   clk, rst               : clock, asynchronous active-low reset
//   En                     : decode takes InstrF/PCPlus4F this cycle
//   Redirect, RedirectPC   : restart fetch at RedirectPC
//   IReq, IAddr, IGnt      : memory request handshake (IAddr = PC)
//   IRValid, IRData        : in-order read responses
//   InstrF, PCPlus4F, ValidF : head of the fetch buffer (zero when empty)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        En,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        IReq,
    output logic [31:0] IAddr,
    input  logic        IGnt,
    input  logic        IRValid,
    input  logic [31:0] IRData,
    output logic [31:0] InstrF,
    output logic [31:0] PCPlus4F,
    output logic        ValidF
);

    logic [31:0]  pc_reg;
    logic [31:0]  pc_next;
    cnt_t         outstanding_reg;
    cnt_t         outstanding_next;
    cnt_t         drop_reg;
    cnt_t         drop_next;

    cnt_t         buf_count;
    fetch_entry_t buf_head;
    fetch_entry_t push_entry;
    logic         buf_valid;
    logic         pop;
    logic         push;
    logic         issue;
    logic         resp_fire;
    cnt_t         live;
    logic [CNT_W:0] credit_used;

    assign buf_valid = (buf_count != '0);
    assign pop       = En && buf_valid;

    // A head leaving this cycle frees its slot right away; without that,
    // zero-wait memory could only sustain two instructions every three cycles.
    assign credit_used = {1'b0, outstanding_reg} + {1'b0, buf_count}
                       - {{CNT_W{1'b0}}, pop};

    // rst gates IReq directly so it is low for the whole reset, not just
    // after the counters have cleared.
    assign IReq  = rst && !Redirect && (credit_used < (CNT_W+1)'(BUF_DEPTH));
    assign IAddr = pc_reg;
    assign issue = IReq && IGnt;

    // Responses with nothing outstanding are spurious and ignored.
    assign resp_fire = IRValid && (outstanding_reg != '0);
    assign push      = resp_fire && (drop_reg == '0) && !Redirect;
    assign live      = outstanding_reg - drop_reg;

    assign push_entry.instr    = IRData;
    assign push_entry.pc_plus4 = resp_pc_plus4(pc_reg, live);

    always_comb begin
        pc_next = pc_reg;
        if (Redirect) begin
            pc_next = RedirectPC;
        end else if (issue) begin
            pc_next = pc_reg + 32'd4;
        end
    end

    always_comb begin
        outstanding_next = outstanding_reg + cnt_t'(issue) - cnt_t'(resp_fire);
        drop_next        = drop_reg;
        if (Redirect) begin
            // IReq is low during Redirect, so nothing new is issued here.
            drop_next = outstanding_reg - cnt_t'(resp_fire);
        end else if (resp_fire && (drop_reg != '0)) begin
            drop_next = drop_reg - cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg          <= RESET_PC;
            outstanding_reg <= '0;
            drop_reg        <= '0;
        end else begin
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
        end
    end

    fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (Redirect),
        .count     (buf_count),
        .head      (buf_head)
    );

    assign ValidF   = buf_valid;
    assign InstrF   = buf_valid ? buf_head.instr    : NOP_INSTR;
    assign PCPlus4F = buf_valid ? buf_head.pc_plus4 : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. A small in-order memory responder returns
// ~addr as the instruction word after 'lat' cycles; a second instance with
// RESET_PC = FFFF_FFF8 is driven by hand to exercise PC wrap-around.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, en, redirect, gnt, mem_rvalid;
    logic [31:0] redirect_pc, mem_rdata;
    logic        ireq, valid;
    logic [31:0] iaddr, instr, pc4;

    logic        w_rst, w_en, w_redirect, w_gnt, w_rvalid;
    logic [31:0] w_redirect_pc, w_rdata;
    logic        w_ireq, w_valid;
    logic [31:0] w_iaddr, w_instr, w_pc4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_unit u_dut (
        .clk(clk), .rst(rst), .En(en), .Redirect(redirect), .RedirectPC(redirect_pc),
        .IReq(ireq), .IAddr(iaddr), .IGnt(gnt), .IRValid(mem_rvalid), .IRData(mem_rdata),
        .InstrF(instr), .PCPlus4F(pc4), .ValidF(valid)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(w_rst), .En(w_en), .Redirect(w_redirect), .RedirectPC(w_redirect_pc),
        .IReq(w_ireq), .IAddr(w_iaddr), .IGnt(w_gnt), .IRValid(w_rvalid), .IRData(w_rdata),
        .InstrF(w_instr), .PCPlus4F(w_pc4), .ValidF(w_valid)
    );

    // Memory model: grants are sampled mid-cycle, responses drive the
    // second half of the cycle they are due in. Reset loses everything.
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end else begin
            if (q.size() != 0 && q[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = ~q[0].addr;
                void'(q.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
            end
            if (ireq && gnt) q.push_back('{addr: iaddr, due: cyc + lat});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; gnt = 1'b1;
        w_rst = 1'b0; w_en = 1'b1; w_redirect = 1'b0; w_redirect_pc = 32'h0;
        w_gnt = 1'b1; w_rvalid = 1'b0; w_rdata = 32'h0;

        // Reset state
        tick(); tick(); #1;
        chk("rst_ireq", ireq, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc4", pc4, 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_w_iaddr", w_iaddr, 32'hFFFF_FFF8);
        chk("rst_w_ireq", w_ireq, 1'b0);

        // Zero-wait memory, first request right after release
        tick(); rst = 1'b1; #1;                         // k0
        chk("k0_ireq", ireq, 1'b1);
        chk("k0_iaddr", iaddr, 32'h0);
        chk("k0_valid", valid, 1'b0);
        tick(); #1;                                     // k1
        chk("k1_iaddr", iaddr, 32'h4);
        chk("k1_valid", valid, 1'b0);
        // Stall five cycles after the first instruction
        tick(); en = 1'b0; #1;                          // k2
        chk("k2_valid", valid, 1'b1);
        chk("k2_instr", instr, 32'hFFFF_FFFF);
        chk("k2_pc4", pc4, 32'h4);
        chk("k2_ireq", ireq, 1'b0);
        for (int i = 0; i < 4; i++) begin               // k3..k6
            tick(); #1;
            chk("stall_ireq", ireq, 1'b0);
            chk("stall_instr", instr, 32'hFFFF_FFFF);
            chk("stall_pc4", pc4, 32'h4);
        end
        tick(); en = 1'b1; #1;                          // k7
        chk("k7_pc4", pc4, 32'h4);
        chk("k7_ireq", ireq, 1'b1);
        chk("k7_iaddr", iaddr, 32'h8);
        tick(); #1;                                     // k8
        chk("k8_pc4", pc4, 32'h8);
        chk("k8_instr", instr, 32'hFFFF_FFFB);
        tick(); #1;                                     // k9
        chk("k9_pc4", pc4, 32'hC);
        chk("k9_instr", instr, 32'hFFFF_FFF7);
        tick(); #1;                                     // k10
        chk("k10_pc4", pc4, 32'h10);
        chk("k10_instr", instr, 32'hFFFF_FFF3);
        chk("k10_ireq", ireq, 1'b1);

        // Reset with a request outstanding and the buffer occupied
        rst = 1'b0; #1;
        chk("mid_rst_valid", valid, 1'b0);
        chk("mid_rst_instr", instr, 32'h0);
        chk("mid_rst_pc4", pc4, 32'h0);
        chk("mid_rst_ireq", ireq, 1'b0);
        chk("mid_rst_iaddr", iaddr, 32'h0);
        lat = 3;
        tick(); tick();
        tick(); rst = 1'b1; #1;                         // m0
        chk("m0_iaddr", iaddr, 32'h0);
        chk("m0_valid", valid, 1'b0);
        tick(); #1;                                     // m1
        chk("m1_iaddr", iaddr, 32'h4);
        // Redirect with two requests in flight
        tick(); redirect = 1'b1; redirect_pc = 32'h0000_0100; #1;  // m2
        chk("m2_ireq", ireq, 1'b0);
        chk("m2_valid", valid, 1'b0);
        tick(); redirect = 1'b0; #1;                    // m3
        chk("m3_iaddr", iaddr, 32'h100);
        chk("m3_ireq", ireq, 1'b0);
        tick(); #1;                                     // m4
        chk("m4_valid", valid, 1'b0);
        chk("m4_ireq", ireq, 1'b1);
        tick(); #1;                                     // m5
        chk("m5_valid", valid, 1'b0);
        chk("m5_iaddr", iaddr, 32'h104);
        tick(); #1;                                     // m6
        chk("m6_ireq", ireq, 1'b0);
        tick(); #1;                                     // m7
        chk("m7_valid", valid, 1'b0);
        tick(); #1;                                     // m8
        chk("m8_valid", valid, 1'b1);
        chk("m8_pc4", pc4, 32'h104);
        chk("m8_instr", instr, 32'hFFFF_FEFF);
        // Redirect coinciding with a response and En
        redirect = 1'b1; redirect_pc = 32'h0000_0200; #1;
        chk("m8_redir_ireq", ireq, 1'b0);
        tick(); redirect = 1'b0; lat = 1; #1;           // m9
        chk("m9_valid", valid, 1'b0);
        chk("m9_instr", instr, 32'h0);
        chk("m9_pc4", pc4, 32'h0);
        chk("m9_iaddr", iaddr, 32'h200);
        chk("m9_ireq", ireq, 1'b1);
        tick(); #1;                                     // m10
        chk("m10_iaddr", iaddr, 32'h204);
        tick(); #1;                                     // m11
        chk("m11_valid", valid, 1'b1);
        chk("m11_pc4", pc4, 32'h204);
        chk("m11_instr", instr, 32'hFFFF_FDFF);

        // PC wrap-around on the second instance
        tick(); w_rst = 1'b1; #1;                       // w0
        chk("w0_iaddr", w_iaddr, 32'hFFFF_FFF8);
        chk("w0_ireq", w_ireq, 1'b1);
        tick(); w_rvalid = 1'b1; w_rdata = 32'h7; #1;   // w1
        chk("w1_iaddr", w_iaddr, 32'hFFFF_FFFC);
        chk("w1_valid", w_valid, 1'b0);
        tick(); w_rdata = 32'h3; w_gnt = 1'b0; #1;      // w2
        chk("w2_iaddr", w_iaddr, 32'h0);
        chk("w2_valid", w_valid, 1'b1);
        chk("w2_pc4", w_pc4, 32'hFFFF_FFFC);
        chk("w2_instr", w_instr, 32'h7);
        tick(); w_rdata = 32'hDEAD_BEEF; #1;            // w3: spurious response
        chk("w3_pc4", w_pc4, 32'h0);
        chk("w3_instr", w_instr, 32'h3);
        tick(); w_rvalid = 1'b0; #1;                    // w4
        chk("w4_valid", w_valid, 1'b0);
        chk("w4_iaddr", w_iaddr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
